sonar_scheduler: RTL and testbench



---
 rtl/sonar_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_sonar_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger and echo timing for three ultrasonic sonar pairs.
// Only one pair fires at a time. Each pair's two echoes are timed independently, and the
// results are published as 8-bit distances on sonar12 / sonar34 / sonar56.
// Optional build macro SONAR_HOLD_ON_TIMEOUT_EN: a timed-out sonar keeps its previous distance
// instead of storing 8'hFF.
module sonar_scheduler #(
    parameter int unsigned TICK_DIV      = 2900,
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned TIMEOUT_TICKS = 300,
    parameter int unsigned GAP_TICKS     = 170
) (
    input  logic        theClock,
    input  logic        theReset,
    input  logic        enable,
    input  logic [5:0]  echo,
    output logic [5:0]  trig,
    output logic [15:0] sonar12,
    output logic [15:0] sonar34,
    output logic [15:0] sonar56,
    output logic        sonar_valid,
    output logic [1:0]  pair_idx,
    output logic        busy
);

    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int unsigned TICK_W = 10;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TICK_W-1:0] TMO_LAST  = TICK_W'(TIMEOUT_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);

    // The rising-edge cycle is itself one high cycle, so it is counted immediately.
    localparam logic [DIV_W-1:0] PRESC_START = (TICK_DIV > 1) ? DIV_W'(1) : DIV_W'(0);
    localparam logic [7:0]       CNT_START   = (TICK_DIV > 1) ? 8'd0 : 8'd1;

    typedef enum logic [2:0] {
        S_Idle   = 3'd0,
        S_Trig   = 3'd1,
        S_Listen = 3'd2,
        S_Store  = 3'd3,
        S_Gap    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SS_WAIT = 2'd0,
        SS_MEAS = 2'd1,
        SS_DONE = 2'd2
    } sonar_st_t;

    // Echo synchroniser
    logic [5:0]        r_echo_s1;
    logic [5:0]        r_echo_s2;

    // Scheduler FSM and shared counters
    state_t            r_state;
    state_t            w_state_nxt;
    logic [TRIG_W-1:0] r_trig_cnt;
    logic [DIV_W-1:0]  r_tick_presc;
    logic [TICK_W-1:0] r_tick_cnt;

    // Per-sonar measurement state for the active pair
    sonar_st_t         r_sst [2];
    sonar_st_t         w_sst_nxt [2];
    logic [DIV_W-1:0]  r_presc [2];
    logic [DIV_W-1:0]  w_presc_nxt [2];
    logic [7:0]        r_cnt [2];
    logic [7:0]        w_cnt_nxt [2];
    logic [1:0]        r_tmo;
    logic [1:0]        w_tmo_nxt;
    logic [1:0]        w_done_nxt;

    // Registered outputs
    logic [5:0]        r_trig;
    logic [15:0]       r_sonar12;
    logic [15:0]       r_sonar34;
    logic [15:0]       r_sonar56;
    logic              r_valid;
    logic [1:0]        r_pair_idx;
    logic              r_busy;

    // Control and datapath wires
    logic [1:0]        w_echo_pair;
    logic              w_tick;
    logic              w_timeout;
    logic              w_gap_end;
    logic              w_trig_end;
    logic              w_clr_sonar;
    logic              w_clr_tick;
    logic [1:0]        w_pair_nxt;
    logic [5:0]        w_trig_nxt;
    logic              w_valid_nxt;
    logic              w_busy_nxt;
    logic [1:0][7:0]   w_store_word;
`ifdef SONAR_HOLD_ON_TIMEOUT_EN
    logic [1:0][7:0]   w_prev_word;
`endif

    assign w_tick      = (r_tick_presc == DIV_LAST);
    assign w_timeout   = (r_state == S_Listen) && w_tick && (r_tick_cnt == TMO_LAST);
    assign w_gap_end   = w_tick && (r_tick_cnt == GAP_LAST);
    assign w_trig_end  = (r_trig_cnt == TRIG_LAST);
    assign w_clr_sonar = (r_state == S_Trig) && w_trig_end;
    assign w_clr_tick  = w_clr_sonar || (r_state == S_Store);

    // Double-flop synchroniser for the asynchronous echo inputs
    always_ff @(posedge theClock) begin
        if (theReset) begin
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
        end
    end

    // Select the synchronised echoes of the pair being scheduled
    always_comb begin
        w_echo_pair = r_echo_s2[1:0];
        case (r_pair_idx)
            2'd1:    w_echo_pair = r_echo_s2[3:2];
            2'd2:    w_echo_pair = r_echo_s2[5:4];
            default: w_echo_pair = r_echo_s2[1:0];
        endcase
    end

    // FSM state register
    always_ff @(posedge theClock) begin
        if (theReset) begin
            r_state <= S_Idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_Idle:   if (enable) w_state_nxt = S_Trig;
            S_Trig:   if (w_trig_end) w_state_nxt = S_Listen;
            S_Listen: if (&w_done_nxt) w_state_nxt = S_Store;
            S_Store:  w_state_nxt = S_Gap;
            S_Gap:    if (w_gap_end) w_state_nxt = enable ? S_Trig : S_Idle;
            default:  w_state_nxt = S_Idle;
        endcase
    end

    // FSM output decode; values are registered on the edge that enters the next state
    always_comb begin
        w_pair_nxt  = r_pair_idx;
        w_trig_nxt  = '0;
        w_valid_nxt = (r_state == S_Store);
        w_busy_nxt  = (w_state_nxt != S_Idle);
        if ((r_state == S_Gap) && w_gap_end) begin
            w_pair_nxt = (r_pair_idx == 2'd2) ? 2'd0 : r_pair_idx + 2'd1;
        end
        if (w_state_nxt == S_Trig) begin
            case (w_pair_nxt)
                2'd1:    w_trig_nxt = 6'b001100;
                2'd2:    w_trig_nxt = 6'b110000;
                default: w_trig_nxt = 6'b000011;
            endcase
        end
    end

    // Trigger pulse length counter
    always_ff @(posedge theClock) begin
        if (theReset) begin
            r_trig_cnt <= '0;
        end else if ((r_state == S_Trig) && !w_trig_end) begin
            r_trig_cnt <= r_trig_cnt + TRIG_W'(1);
        end else begin
            r_trig_cnt <= '0;
        end
    end

    // Pair tick counter: timeout reference in S_Listen, gap timer in S_Gap
    always_ff @(posedge theClock) begin
        if (theReset) begin
            r_tick_presc <= '0;
            r_tick_cnt   <= '0;
        end else if (w_clr_tick) begin
            r_tick_presc <= '0;
            r_tick_cnt   <= '0;
        end else if ((r_state == S_Listen) || (r_state == S_Gap)) begin
            if (w_tick) begin
                r_tick_presc <= '0;
                r_tick_cnt   <= r_tick_cnt + TICK_W'(1);
            end else begin
                r_tick_presc <= r_tick_presc + DIV_W'(1);
            end
        end
    end

    // Per-sonar wait-rise / measure / done sequencing; a falling echo beats a same-cycle timeout
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_sst_nxt[k]   = r_sst[k];
            w_presc_nxt[k] = r_presc[k];
            w_cnt_nxt[k]   = r_cnt[k];
            w_tmo_nxt[k]   = r_tmo[k];
            if (w_clr_sonar) begin
                w_sst_nxt[k]   = SS_WAIT;
                w_presc_nxt[k] = '0;
                w_cnt_nxt[k]   = '0;
                w_tmo_nxt[k]   = 1'b0;
            end else if (r_state == S_Listen) begin
                case (r_sst[k])
                    SS_WAIT: begin
                        if (w_timeout) begin
                            w_sst_nxt[k] = SS_DONE;
                            w_tmo_nxt[k] = 1'b1;
                        end else if (w_echo_pair[k]) begin
                            w_sst_nxt[k]   = SS_MEAS;
                            w_presc_nxt[k] = PRESC_START;
                            w_cnt_nxt[k]   = CNT_START;
                        end
                    end
                    SS_MEAS: begin
                        if (!w_echo_pair[k]) begin
                            w_sst_nxt[k] = SS_DONE;
                        end else if (w_timeout) begin
                            w_sst_nxt[k] = SS_DONE;
                            w_tmo_nxt[k] = 1'b1;
                        end else if (r_presc[k] == DIV_LAST) begin
                            w_presc_nxt[k] = '0;
                            if (r_cnt[k] != 8'hFF) begin
                                w_cnt_nxt[k] = r_cnt[k] + 8'd1;
                            end
                        end else begin
                            w_presc_nxt[k] = r_presc[k] + DIV_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            w_done_nxt[k] = (w_sst_nxt[k] == SS_DONE);
        end
    end

    // Per-sonar measurement registers
    always_ff @(posedge theClock) begin
        if (theReset) begin
            for (int k = 0; k < 2; k++) begin
                r_sst[k]   <= SS_WAIT;
                r_presc[k] <= '0;
                r_cnt[k]   <= '0;
            end
            r_tmo <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_sst[k]   <= w_sst_nxt[k];
                r_presc[k] <= w_presc_nxt[k];
                r_cnt[k]   <= w_cnt_nxt[k];
            end
            r_tmo <= w_tmo_nxt;
        end
    end

    // Result word for the active pair: measured counts, with timed-out sonars substituted
    always_comb begin
`ifdef SONAR_HOLD_ON_TIMEOUT_EN
        case (r_pair_idx)
            2'd1:    w_prev_word = r_sonar34;
            2'd2:    w_prev_word = r_sonar56;
            default: w_prev_word = r_sonar12;
        endcase
`endif
        for (int k = 0; k < 2; k++) begin
            w_store_word[k] = r_cnt[k];
            if (r_tmo[k]) begin
`ifdef SONAR_HOLD_ON_TIMEOUT_EN
                w_store_word[k] = w_prev_word[k];
`else
                w_store_word[k] = 8'hFF;
`endif
            end
        end
    end

    // Output registers; only the active pair's bus is written, in S_Store
    always_ff @(posedge theClock) begin
        if (theReset) begin
            r_trig     <= '0;
            r_sonar12  <= '0;
            r_sonar34  <= '0;
            r_sonar56  <= '0;
            r_valid    <= 1'b0;
            r_pair_idx <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_trig     <= w_trig_nxt;
            r_valid    <= w_valid_nxt;
            r_pair_idx <= w_pair_nxt;
            r_busy     <= w_busy_nxt;
            if (r_state == S_Store) begin
                case (r_pair_idx)
                    2'd0:    r_sonar12 <= w_store_word;
                    2'd1:    r_sonar34 <= w_store_word;
                    2'd2:    r_sonar56 <= w_store_word;
                    default: ;
                endcase
            end
        end
    end

    assign trig        = r_trig;
    assign sonar12     = r_sonar12;
    assign sonar34     = r_sonar34;
    assign sonar56     = r_sonar56;
    assign sonar_valid = r_valid;
    assign pair_idx    = r_pair_idx;
    assign busy        = r_busy;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed bench for sonar_scheduler with short tick/trigger/timeout settings.
// A second instance with a long timeout exercises distance saturation.
module tb_sonar_scheduler;

    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned TRIG_CYCLES   = 3;
    localparam int unsigned TIMEOUT_TICKS = 20;
    localparam int unsigned GAP_TICKS     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  echo;
    logic [5:0]  trig;
    logic [15:0] s12;
    logic [15:0] s34;
    logic [15:0] s56;
    logic        valid;
    logic [1:0]  pidx;
    logic        busy;

    logic        en_s;
    logic [5:0]  echo_s;
    logic [5:0]  trig_s;
    logic [15:0] s12_s;
    logic [15:0] s34_s;
    logic [15:0] s56_s;
    logic        valid_s;
    logic [1:0]  pidx_s;
    logic        busy_s;

    int          checks = 0;
    int          errors = 0;
    bit          bad_trig = 1'b0;
    logic [15:0] exp56;
    bit          seen;

    always #5 clk = ~clk;

    sonar_scheduler #(
        .TICK_DIV(TICK_DIV), .TRIG_CYCLES(TRIG_CYCLES),
        .TIMEOUT_TICKS(TIMEOUT_TICKS), .GAP_TICKS(GAP_TICKS)
    ) u_dut (
        .theClock(clk), .theReset(rst), .enable(en), .echo(echo), .trig(trig),
        .sonar12(s12), .sonar34(s34), .sonar56(s56), .sonar_valid(valid),
        .pair_idx(pidx), .busy(busy)
    );

    sonar_scheduler #(
        .TICK_DIV(TICK_DIV), .TRIG_CYCLES(TRIG_CYCLES),
        .TIMEOUT_TICKS(300), .GAP_TICKS(GAP_TICKS)
    ) u_sat (
        .theClock(clk), .theReset(rst), .enable(en_s), .echo(echo_s), .trig(trig_s),
        .sonar12(s12_s), .sonar34(s34_s), .sonar56(s56_s), .sonar_valid(valid_s),
        .pair_idx(pidx_s), .busy(busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; flag any overlapping pair triggers
    task automatic tick();
        @(posedge clk);
        #1;
        if (!(trig inside {6'b000000, 6'b000011, 6'b001100, 6'b110000})) bad_trig = 1'b1;
    endtask

    function automatic logic [15:0] bus_of(input int p);
        case (p)
            1:       return s34;
            2:       return s56;
            default: return s12;
        endcase
    endfunction

    // One pair: check trigger, drive echo pulses (length in clocks, 0 = never rises), check result
    task automatic do_pair(input string name, input int p, input int n_lo, input int n_hi,
                           input logic [15:0] exp, input bit drop_en);
        logic [5:0] mask;
        logic [5:0] lo_m;
        logic [5:0] hi_m;
        int         n;
        int         t_end;
        bit         ok;
        mask = 6'(3 << (2 * p));
        lo_m = 6'(1 << (2 * p));
        hi_m = 6'(2 << (2 * p));
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (trig != 6'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_trig_rise"}, 32'(ok), 32'd1);
        chk({name, "_trig_mask"}, 32'(trig), 32'(mask));
        n = 0;
        while (trig != 6'b0 && n < 20) begin
            n++;
            tick();
        end
        chk({name, "_trig_len"}, 32'(n), TRIG_CYCLES);
        if (drop_en) en = 1'b0;
        if (n_lo > 0) echo = echo | lo_m;
        if (n_hi > 0) echo = echo | hi_m;
        t_end = (n_lo > n_hi) ? n_lo : n_hi;
        for (int t = 1; t <= t_end; t++) begin
            tick();
            if (t == n_lo) echo = echo & ~lo_m;
            if (t == n_hi) echo = echo & ~hi_m;
        end
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_valid_seen"}, 32'(ok), 32'd1);
        chk({name, "_bus"}, 32'(bus_of(p)), 32'(exp));
        chk({name, "_pair_idx"}, 32'(pidx), 32'(p));
        tick();
        chk({name, "_valid_one_cycle"}, 32'(valid), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        echo   = '0;
        en_s   = 1'b0;
        echo_s = '0;
`ifdef SONAR_HOLD_ON_TIMEOUT_EN
        exp56 = 16'h0502;
`else
        exp56 = 16'h05FF;
`endif
        repeat (3) tick();
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_s12", 32'(s12), 32'd0);
        chk("rst_s34", 32'(s34), 32'd0);
        chk("rst_s56", 32'(s56), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pidx", 32'(pidx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_trig", 32'(trig), 32'd0);

        // trig rises on the first clock after Idle samples enable
        en = 1'b1;
        tick();
        chk("trig_first_clock", 32'(trig), 32'h03);
        chk("busy_in_trig", 32'(busy), 32'd1);
        do_pair("t1_p0", 0, 40, 12, 16'h030A, 1'b0);

        // Continuous rotation through the pairs
        do_pair("t2_p1", 1, 8, 8, 16'h0202, 1'b0);
        chk("t2_hold_s12", 32'(s12), 32'h030A);
        do_pair("t2_p2", 2, 8, 8, 16'h0202, 1'b0);
        do_pair("t2_p0", 0, 8, 8, 16'h0202, 1'b0);

        // Echo 3 falls in the very cycle the timeout fires: counted value 77/4 = 19 wins
        do_pair("t4_fall_at_tmo", 1, 77, 8, 16'h0213, 1'b0);

        // Echo 5 never rises (timeout), echo 6 high 20 clocks
        do_pair("t3_timeout", 2, 0, 20, exp56, 1'b0);
        chk("t3_hold_s34", 32'(s34), 32'h0213);
        chk("t3_hold_s12", 32'(s12), 32'h0202);

        // Enable dropped during pair 1 listen: pair completes, FSM parks after the gap
        do_pair("t5_p0", 0, 8, 8, 16'h0202, 1'b0);
        do_pair("t5_p1", 1, 8, 8, 16'h0202, 1'b1);
        repeat (6) tick();
        chk("t5_busy_in_gap", 32'(busy), 32'd1);
        chk("t5_pidx_in_gap", 32'(pidx), 32'd1);
        tick();
        chk("t5_busy_parked", 32'(busy), 32'd0);
        chk("t5_pidx_parked", 32'(pidx), 32'd2);
        chk("t5_trig_parked", 32'(trig), 32'd0);
        repeat (3) tick();
        chk("t5_still_parked", 32'(busy), 32'd0);
        en = 1'b1;
        tick();
        chk("t5_restart_pair2", 32'(trig), 32'h30);

        // Reset during S_Trig
        tick();
        rst = 1'b1;
        tick();
        chk("t6_trig", 32'(trig), 32'd0);
        chk("t6_s12", 32'(s12), 32'd0);
        chk("t6_s34", 32'(s34), 32'd0);
        chk("t6_s56", 32'(s56), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pidx", 32'(pidx), 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) tick();
        chk("t6_idle_after", 32'(busy), 32'd0);
        chk("no_trig_overlap", 32'(bad_trig), 32'd0);

        // Saturation: echo 1 high 1100 clocks (275 ticks -> 255), echo 2 high 40 clocks
        en_s = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (trig_s != 6'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t4s_trig_rise", 32'(seen), 32'd1);
        chk("t4s_trig_mask", 32'(trig_s), 32'h03);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (trig_s == 6'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t4s_trig_fall", 32'(seen), 32'd1);
        en_s   = 1'b0;
        echo_s = 6'b000011;
        for (int t = 1; t <= 1100; t++) begin
            tick();
            if (t == 40) echo_s = echo_s & 6'b111101;
            if (t == 1100) echo_s = 6'b000000;
        end
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (valid_s) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t4s_valid_seen", 32'(seen), 32'd1);
        chk("t4s_s12", 32'(s12_s), 32'h0AFF);
        chk("t4s_pidx", 32'(pidx_s), 32'd0);
        chk("t4s_s34", 32'(s34_s), 32'd0);
        chk("t4s_s56", 32'(s56_s), 32'd0);
        repeat (10) tick();
        chk("t4s_busy_parked", 32'(busy_s), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
